mips_dmem_responder: RTL and testbench

Memory-side responder for the MIPS CPU's data port: the target end of the load/store request interface the CPU core initiates. It accepts one word request at a time over a valid/ready handshake and waits a programmable latency. It then performs a byte-enabled write or a word read on an internal array and returns a response over a second valid/ready handshake. It replaces the zero-latency combinational data memory so the CPU can be exercised against realistic memory timing and error responses.

---
 rtl/mips_mem_pkg.sv | 18 +
 rtl/mips_dmem_array.sv | 32 +++
 rtl/mips_dmem_responder.sv | 137 +++++++++++++
 tb/tb_mips_dmem_responder.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the MIPS memory-side responders.
// The data-side responder uses it, and an instruction-side responder is meant to reuse it.
package mips_mem_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int BE_W   = 4;

  localparam logic RESP_OK  = 1'b0;
  localparam logic RESP_ERR = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } mem_state_e;

endpackage

// File: rtl/mips_dmem_array.sv
// Word-organised data array with a byte-enabled synchronous write and a combinational read.
// The storage is 2-state, so it starts at zero and reset never clears it.
module mips_dmem_array
  import mips_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  localparam int IDX_W = $clog2(DEPTH_WORDS)
) (
  input  logic              clock,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [BE_W-1:0]   wr_be,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data
);

  bit [DATA_W-1:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int b = 0; b < BE_W; b++) begin
        if (wr_be[b]) begin
          mem_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/mips_dmem_responder.sv
// Data-port memory responder: request handshake, programmable latency, and a
// byte-enabled access with an error check. The response is held until the initiator takes it.
module mips_dmem_responder
  import mips_mem_pkg::*;
#(
  parameter int                DEPTH_WORDS = 256,
  parameter int                LATENCY     = 2,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              busy
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  mem_state_e        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [ADDR_W-1:0] word_off;
  logic              addr_err;
  logic              wr_en;
  logic [DATA_W-1:0] rd_word;

  // Subtraction wraps, so an address below BASE_ADDR lands far out of range.
  assign word_off = (addr_q - BASE_ADDR) >> 2;
  assign addr_err = (addr_q[1:0] != 2'b00) || (word_off >= ADDR_W'(DEPTH_WORDS));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    wr_en   = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          be_d    = req_be;
          cnt_d   = 4'(LATENCY - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = RESP;
          rdata_d = '0;
          if (addr_err) begin
            err_d = RESP_ERR;
          end else begin
            err_d = RESP_OK;
            if (write_q) begin
              wr_en = 1'b1;
            end else begin
              rdata_d = rd_word;
            end
          end
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
          rdata_d = '0;
          err_d   = RESP_OK;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      err_q   <= RESP_OK;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // A reset landing on the access edge must not let the pending store commit.
  mips_dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clock  (clock),
    .wr_en  (wr_en && !reset),
    .wr_idx (word_off[IDX_W-1:0]),
    .wr_data(wdata_q),
    .wr_be  (be_q),
    .rd_idx (word_off[IDX_W-1:0]),
    .rd_data(rd_word)
  );

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign busy       = (state_q != IDLE);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_mips_dmem_responder.sv
// Directed bench for mips_dmem_responder: three instances (base config, offset BASE_ADDR,
// LATENCY=1) share one stimulus bus, and sel chooses which one is driven and observed.
module tb_mips_dmem_responder;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        resp_ready = 1'b0;

  logic        req_ready, resp_valid, resp_err, busy;
  logic [31:0] resp_rdata;

  int sel = 0;
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  int acc_q[$];
  logic [31:0] rsp_q[$];

  logic [2:0]  rv_i, rr_i, rq_o, vv_o, er_o, bz_o;
  logic [31:0] rd_o [3];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  for (genvar k = 0; k < 3; k++) begin : g_gate
    assign rv_i[k] = req_valid && (sel == k);
    assign rr_i[k] = resp_ready && (sel == k);
  end

  assign req_ready  = rq_o[sel];
  assign resp_valid = vv_o[sel];
  assign resp_err   = er_o[sel];
  assign busy       = bz_o[sel];
  assign resp_rdata = rd_o[sel];

  mips_dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2), .BASE_ADDR(32'h0000_0000)) dut0 (
    .clock(clock), .reset(reset), .req_valid(rv_i[0]), .req_ready(rq_o[0]),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(vv_o[0]), .resp_ready(rr_i[0]), .resp_rdata(rd_o[0]), .resp_err(er_o[0]),
    .busy(bz_o[0]));

  mips_dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2), .BASE_ADDR(32'h0000_1000)) dut1 (
    .clock(clock), .reset(reset), .req_valid(rv_i[1]), .req_ready(rq_o[1]),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(vv_o[1]), .resp_ready(rr_i[1]), .resp_rdata(rd_o[1]), .resp_err(er_o[1]),
    .busy(bz_o[1]));

  mips_dmem_responder #(.DEPTH_WORDS(256), .LATENCY(1), .BASE_ADDR(32'h0000_0000)) dut2 (
    .clock(clock), .reset(reset), .req_valid(rv_i[2]), .req_ready(rq_o[2]),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(vv_o[2]), .resp_ready(rr_i[2]), .resp_rdata(rd_o[2]), .resp_err(er_o[2]),
    .busy(bz_o[2]));

  // Records accept cycles and taken responses; sampled mid-cycle, so each is the upcoming edge's event.
  always @(negedge clock) begin
    if (mon_en) begin
      if (req_valid && req_ready) acc_q.push_back(cyc);
      if (resp_valid && resp_ready) rsp_q.push_back(resp_rdata);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drives one request, waits for it to be accepted, then scrambles the bus.
  task automatic applyStimulus(input logic wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] be);
    int n;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    checkOutput("accept_ready", {31'b0, req_ready}, 32'd1);
    @(posedge clock); #1;
    req_valid = 1'b0;
    req_write = ~wr;
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_be    = 4'($urandom);
  endtask

  task automatic waitResp(input string tag, input int exp_lat);
    int n;
    n = 0;
    while (!resp_valid && n < 40) begin
      @(posedge clock); #1;
      n++;
    end
    checkOutput({tag, "_lat"}, n, exp_lat);
  endtask

  task automatic takeResp(input string tag, input logic [31:0] exp_rdata, input logic exp_err);
    checkOutput({tag, "_rdata"}, resp_rdata, exp_rdata);
    checkOutput({tag, "_err"}, {31'b0, resp_err}, {31'b0, exp_err});
    checkOutput({tag, "_busy"}, {31'b0, busy}, 32'd1);
    resp_ready = 1'b1;
    @(posedge clock); #1;
    resp_ready = 1'b0;
    checkOutput({tag, "_vdrop"}, {31'b0, resp_valid}, 32'd0);
    checkOutput({tag, "_rdy"}, {31'b0, req_ready}, 32'd1);
  endtask

  task automatic doTxn(input string tag, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be, input int lat,
                       input logic [31:0] exp_rdata, input logic exp_err);
    applyStimulus(wr, addr, wdata, be);
    waitResp(tag, lat);
    takeResp(tag, exp_rdata, exp_err);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [31:0] exp_rsp [3];
    logic [31:0] held_rdata;

    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    checkOutput("rst_req_ready", {31'b0, req_ready}, 32'd1);
    checkOutput("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    checkOutput("rst_rdata", resp_rdata, 32'd0);
    checkOutput("rst_err", {31'b0, resp_err}, 32'd0);
    checkOutput("rst_busy", {31'b0, busy}, 32'd0);

    sel = 0;
    doTxn("st10", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 2, 32'h0, 1'b0);
    doTxn("ld10", 1'b0, 32'h10, 32'h0, 4'h0, 2, 32'hDEADBEEF, 1'b0);
    doTxn("st20a", 1'b1, 32'h20, 32'h11223344, 4'hF, 2, 32'h0, 1'b0);
    doTxn("st20b", 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 2, 32'h0, 1'b0);
    doTxn("ld20", 1'b0, 32'h20, 32'h0, 4'hF, 2, 32'h11BB33DD, 1'b0);
    doTxn("st20z", 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, 2, 32'h0, 1'b0);
    doTxn("ld20z", 1'b0, 32'h20, 32'h0, 4'h0, 2, 32'h11BB33DD, 1'b0);
    doTxn("ld22", 1'b0, 32'h22, 32'h0, 4'h0, 2, 32'h0, 1'b1);
    doTxn("st400", 1'b1, 32'h400, 32'h55555555, 4'hF, 2, 32'h0, 1'b1);
    doTxn("ld00", 1'b0, 32'h0, 32'h0, 4'h0, 2, 32'h0, 1'b0);

    // Backpressure: response stays put while resp_ready is low.
    applyStimulus(1'b0, 32'h10, 32'h0, 4'h0);
    waitResp("bp", 2);
    held_rdata = resp_rdata;
    checkOutput("bp_first", held_rdata, 32'hDEADBEEF);
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      checkOutput("bp_valid", {31'b0, resp_valid}, 32'd1);
      checkOutput("bp_rdata", resp_rdata, 32'hDEADBEEF);
      checkOutput("bp_err", {31'b0, resp_err}, 32'd0);
      checkOutput("bp_req_ready", {31'b0, req_ready}, 32'd0);
    end
    takeResp("bp", 32'hDEADBEEF, 1'b0);

    // Reset on the very edge that would commit the store.
    doTxn("st30", 1'b1, 32'h30, 32'h12345678, 4'hF, 2, 32'h0, 1'b0);
    applyStimulus(1'b1, 32'h30, 32'hCAFEF00D, 4'hF);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    checkOutput("rw_resp_valid", {31'b0, resp_valid}, 32'd0);
    checkOutput("rw_req_ready", {31'b0, req_ready}, 32'd1);
    checkOutput("rw_busy", {31'b0, busy}, 32'd0);
    repeat (4) @(posedge clock);
    #1 checkOutput("rw_no_resp", {31'b0, resp_valid}, 32'd0);
    doTxn("ld30", 1'b0, 32'h30, 32'h0, 4'h0, 2, 32'h12345678, 1'b0);

    // Reset while a response is pending.
    applyStimulus(1'b0, 32'h10, 32'h0, 4'h0);
    waitResp("rr", 2);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    checkOutput("rr_resp_valid", {31'b0, resp_valid}, 32'd0);
    checkOutput("rr_req_ready", {31'b0, req_ready}, 32'd1);
    checkOutput("rr_rdata", resp_rdata, 32'd0);
    doTxn("ld10b", 1'b0, 32'h10, 32'h0, 4'h0, 2, 32'hDEADBEEF, 1'b0);

    sel = 1;
    doTxn("b_ldffc", 1'b0, 32'h0FFC, 32'h0, 4'h0, 2, 32'h0, 1'b1);
    doTxn("b_st1000", 1'b1, 32'h1000, 32'h0BADCAFE, 4'hF, 2, 32'h0, 1'b0);
    doTxn("b_ld1000", 1'b0, 32'h1000, 32'h0, 4'h0, 2, 32'h0BADCAFE, 1'b0);
    doTxn("b_ld13fc", 1'b0, 32'h13FC, 32'h0, 4'h0, 2, 32'h0, 1'b0);
    doTxn("b_ld1400", 1'b0, 32'h1400, 32'h0, 4'h0, 2, 32'h0, 1'b1);

    // LATENCY=1 with req_valid held high and resp_ready always high.
    sel = 2;
    exp_rsp[0] = 32'h0;
    exp_rsp[1] = 32'h0;
    exp_rsp[2] = 32'hA5A5A5A5;
    resp_ready = 1'b1;
    @(posedge clock); #1;
    mon_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      int n;
      req_write = (i != 2);
      req_addr  = (i == 1) ? 32'h44 : 32'h40;
      req_wdata = (i == 0) ? 32'hA5A5A5A5 : 32'h5A5A5A5A;
      req_be    = 4'hF;
      req_valid = 1'b1;
      n = 0;
      while (!req_ready && n < 20) begin
        @(posedge clock); #1;
        n++;
      end
      @(posedge clock); #1;
    end
    req_valid = 1'b0;
    repeat (6) @(posedge clock);
    #1 mon_en = 1'b0;
    resp_ready = 1'b0;
    checkOutput("b2b_nacc", acc_q.size(), 32'd3);
    for (int i = 1; i < acc_q.size(); i++) begin
      checkOutput("b2b_spacing", acc_q[i] - acc_q[i-1], 32'd3);
    end
    checkOutput("b2b_nresp", rsp_q.size(), 32'd3);
    for (int i = 0; i < rsp_q.size() && i < 3; i++) begin
      checkOutput("b2b_rdata", rsp_q[i], exp_rsp[i]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
